sisc_mdu: RTL and testbench

//  Parametrised iterative multiply/divide unit for the next-generation SISC datapath; extends the ALU's

---
 rtl/sisc_mdu.sv | 199 +++++++++++++++++++
 tb/tb_sisc_mdu.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sisc_mdu.sv
// sisc_mdu: iterative multiply/divide unit beside the ALU.
// One shift-add / shift-subtract step per cycle, start/done handshake.
module sisc_mdu #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic             start,
  input  logic             abort,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       cc
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_FIN
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q, q_q, m_q;
  logic             is_div_q, sgn_q;
  logic             neg_lo_q, neg_hi_q;
  logic             div0_q, ovf_q;
  logic [WIDTH-1:0] res_lo_q, res_hi_q;
  logic [3:0]       cc_q;

  logic             op_sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             div0_in, ovf_in, accept;

  logic [WIDTH:0]   mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0] fin_lo, fin_hi;
  logic [3:0]       fin_cc;

  assign ready = (state_q == S_IDLE) && !rst_f;
  assign busy  = (state_q == S_BUSY);
  assign done  = (state_q == S_FIN);

  assign accept = (state_q == S_IDLE) && start && !abort;

  // Operand conditioning: magnitudes and special cases at accept.
  always_comb begin
    op_sgn  = SIGNED_EN && op[0];
    a_neg   = op_sgn && a[WIDTH-1];
    b_neg   = op_sgn && b[WIDTH-1];
    a_mag   = a_neg ? -a : a;
    b_mag   = b_neg ? -b : b;
    div0_in = op[1] && (b == '0);
    ovf_in  = op[1] && op_sgn && (b == '1)
              && (a == {1'b1, {(WIDTH-1){1'b0}}});
  end

  // One iteration step for each operation class.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (q_q[0] ? {1'b0, m_q} : '0);
    div_sh   = {acc_q, q_q[WIDTH-1]};
    div_diff = div_sh - {1'b0, m_q};
  end

  // Sign fixup and condition codes for the finishing cycle.
  always_comb begin
    prod     = {acc_q, q_q};
    prod_fix = neg_lo_q ? -prod : prod;
    fin_lo   = prod_fix[WIDTH-1:0];
    fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
    fin_cc   = 4'b0000;
    if (is_div_q) begin
      if (div0_q) begin
        fin_lo = q_q;
        fin_hi = acc_q;
      end else begin
        fin_lo = neg_lo_q ? -q_q : q_q;
        fin_hi = neg_hi_q ? -acc_q : acc_q;
      end
      fin_cc[3] = (fin_hi != '0);
      fin_cc[2] = sgn_q && fin_lo[WIDTH-1];
      fin_cc[1] = (fin_lo == '0);
      fin_cc[0] = div0_q || ovf_q;
    end else begin
      fin_cc[3] = (fin_hi != '0);
      fin_cc[2] = sgn_q && fin_hi[WIDTH-1];
      fin_cc[1] = (fin_hi == '0) && (fin_lo == '0);
      fin_cc[0] = sgn_q ? (fin_hi != {WIDTH{fin_lo[WIDTH-1]}})
                        : (fin_hi != '0);
    end
  end

  // Results are visible during done, committed unless aborted.
  always_comb begin
    result_lo = res_lo_q;
    result_hi = res_hi_q;
    cc        = cc_q;
    if (state_q == S_FIN) begin
      result_lo = fin_lo;
      result_hi = fin_hi;
      cc        = fin_cc;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst_f) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; divide by zero skips the iteration phase.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) state_d = div0_in ? S_FIN : S_BUSY;
      end
      S_BUSY: begin
        if (abort)                 state_d = S_IDLE;
        else if (cnt_q == CNT_ONE) state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result commit.
  always_ff @(posedge clk) begin
    if (rst_f) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      m_q      <= '0;
      is_div_q <= 1'b0;
      sgn_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
      ovf_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      cc_q     <= '0;
    end else begin
      if (accept) begin
        cnt_q    <= CNT_INIT;
        is_div_q <= op[1];
        sgn_q    <= op_sgn;
        neg_lo_q <= a_neg ^ b_neg;
        neg_hi_q <= a_neg;
        div0_q   <= div0_in;
        ovf_q    <= ovf_in;
        if (!op[1]) begin
          acc_q <= '0;
          q_q   <= b_mag;
          m_q   <= a_mag;
        end else if (div0_in) begin
          acc_q <= a;
          q_q   <= '1;
          m_q   <= '0;
        end else begin
          acc_q <= '0;
          q_q   <= a_mag;
          m_q   <= b_mag;
        end
      end else if (state_q == S_BUSY && !abort) begin
        cnt_q <= cnt_q - CNT_ONE;
        if (is_div_q) begin
          if (!div_diff[WIDTH]) begin
            acc_q <= div_diff[WIDTH-1:0];
            q_q   <= {q_q[WIDTH-2:0], 1'b1};
          end else begin
            acc_q <= div_sh[WIDTH-1:0];
            q_q   <= {q_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          acc_q <= mul_sum[WIDTH:1];
          q_q   <= {mul_sum[0], q_q[WIDTH-1:1]};
        end
      end
      if (state_q == S_FIN && !abort) begin
        res_lo_q <= fin_lo;
        res_hi_q <= fin_hi;
        cc_q     <= fin_cc;
      end
    end
  end

endmodule

// File: tb/tb_sisc_mdu.sv
// tb_sisc_mdu: table vectors, control sequences and random ops
// checked against an arithmetic reference model.
module tb_sisc_mdu;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_f, start, abort;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         ready, busy, done;
  logic [W-1:0] lo, hi;
  logic [3:0]   cc;
  logic         ready_u, busy_u, done_u;
  logic [W-1:0] lo_u, hi_u;
  logic [3:0]   cc_u;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  sisc_mdu #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .rst_f(rst_f), .start(start), .abort(abort),
    .op(op), .a(a), .b(b),
    .ready(ready), .busy(busy), .done(done),
    .result_lo(lo), .result_hi(hi), .cc(cc)
  );

  sisc_mdu #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .rst_f(rst_f), .start(start), .abort(abort),
    .op(op), .a(a), .b(b),
    .ready(ready_u), .busy(busy_u), .done(done_u),
    .result_lo(lo_u), .result_hi(hi_u), .cc(cc_u)
  );

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic [3:0]   cc;
    int           lat;
  } vec_t;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference results straight from two's complement arithmetic.
  function automatic void model(
    input  logic [1:0]   mop,
    input  logic [W-1:0] ma, mb,
    input  bit           sen,
    output logic [W-1:0] elo, ehi,
    output logic [3:0]   ecc
  );
    bit sg;
    longint sa, sb;
    logic [63:0] p;
    int ia, ib;
    logic c, n, z, v;
    sg = sen && mop[0];
    if (!mop[1]) begin
      if (sg) begin
        sa = longint'($signed(ma));
        sb = longint'($signed(mb));
        p  = 64'(sa * sb);
      end else begin
        p = {32'b0, ma} * {32'b0, mb};
      end
      elo = p[31:0];
      ehi = p[63:32];
      c = (ehi != 0);
      n = sg ? ehi[31] : 1'b0;
      z = (p == 0);
      v = sg ? (ehi != {32{elo[31]}}) : (ehi != 0);
    end else begin
      if (mb == 0) begin
        elo = '1; ehi = ma; v = 1'b1;
      end else if (sg && ma == 32'h8000_0000 && mb == 32'hffff_ffff) begin
        elo = ma; ehi = '0; v = 1'b1;
      end else if (sg) begin
        ia = $signed(ma);
        ib = $signed(mb);
        elo = ia / ib;
        ehi = ia % ib;
        v = 1'b0;
      end else begin
        elo = ma / mb;
        ehi = ma % mb;
        v = 1'b0;
      end
      c = (ehi != 0);
      n = sg ? elo[31] : 1'b0;
      z = (elo == 0);
    end
    ecc = {c, n, z, v};
  endfunction

  // Issue one op on both units, return latency and done-cycle outputs.
  task automatic run(
    input  logic [1:0]   top,
    input  logic [W-1:0] ta, tb,
    output int           lat,
    output logic [W-1:0] olo, ohi, ulo, uhi,
    output logic [3:0]   occ, ucc
  );
    int n;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    chk("ready_before_start", {63'b0, ready}, 64'd1);
    op = top; a = ta; b = tb; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 1;
    while (!done && lat < 60) begin
      tick();
      lat++;
    end
    chk("done_u_aligned", {63'b0, done_u}, 64'd1);
    olo = lo; ohi = hi; occ = cc;
    ulo = lo_u; uhi = hi_u; ucc = cc_u;
    tick();
    chk("done_one_cycle", {62'b0, done, done_u}, 64'd0);
    chk("held_after_done", {lo, hi}, {olo, ohi});
  endtask

  vec_t vt[10];
  int lat;
  logic [W-1:0] rlo, rhi, rulo, ruhi, elo, ehi, plo, phi;
  logic [3:0] rcc, rucc, ecc, pcc;
  logic [1:0] rop;
  logic [W-1:0] ra, rb;
  bit seen;

  initial begin
    vt[0] = '{2'b00, 32'hffff_ffff, 32'd2, 32'hffff_fffe, 32'h1, 4'b1001, 33};
    vt[1] = '{2'b01, 32'hffff_fffd, 32'd5, 32'hffff_fff1, 32'hffff_ffff, 4'b1100, 33};
    vt[2] = '{2'b11, 32'hffff_fff9, 32'd2, 32'hffff_fffd, 32'hffff_ffff, 4'b1100, 33};
    vt[3] = '{2'b10, 32'h0, 32'd5, 32'h0, 32'h0, 4'b0010, 33};
    vt[4] = '{2'b10, 32'h1234, 32'h0, 32'hffff_ffff, 32'h1234, 4'b1001, 1};
    vt[5] = '{2'b11, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 32'h0, 4'b0101, 33};
    vt[6] = '{2'b00, 32'h0, 32'h1234_5678, 32'h0, 32'h0, 4'b0010, 33};
    vt[7] = '{2'b11, 32'd7, 32'hffff_fffe, 32'hffff_fffd, 32'h1, 4'b1100, 33};
    vt[8] = '{2'b11, 32'hffff_fff9, 32'h0, 32'hffff_ffff, 32'hffff_fff9, 4'b1101, 1};
    vt[9] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h0, 32'h4000_0000, 4'b1001, 33};

    rst_f = 1'b1; start = 1'b0; abort = 1'b0; op = 2'b00; a = '0; b = '0;
    tick();
    tick();
    chk("rst_ready", {62'b0, ready, ready_u}, 64'd0);
    chk("rst_busy_done", {62'b0, busy, done}, 64'd0);
    chk("rst_results", {lo, hi}, 64'd0);
    chk("rst_cc", {60'b0, cc}, 64'd0);
    rst_f = 1'b0;
    tick();
    chk("ready_after_rst", {63'b0, ready}, 64'd1);

    abort = 1'b1; start = 1'b1; op = 2'b00; a = 32'd3; b = 32'd4;
    tick();
    abort = 1'b0; start = 1'b0;
    chk("abort_start_idle_busy", {62'b0, busy, done}, 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done || busy) seen = 1'b1;
    end
    chk("abort_start_idle_no_op", {63'b0, seen}, 64'd0);

    for (int i = 0; i < 10; i++) begin
      run(vt[i].op, vt[i].a, vt[i].b, lat, rlo, rhi, rulo, ruhi, rcc, rucc);
      chk($sformatf("vec%0d_lat", i), 64'(lat), 64'(vt[i].lat));
      chk($sformatf("vec%0d_lo", i), {32'b0, rlo}, {32'b0, vt[i].lo});
      chk($sformatf("vec%0d_hi", i), {32'b0, rhi}, {32'b0, vt[i].hi});
      chk($sformatf("vec%0d_cc", i), {60'b0, rcc}, {60'b0, vt[i].cc});
      model(vt[i].op, vt[i].a, vt[i].b, 1'b0, elo, ehi, ecc);
      chk($sformatf("vec%0d_u", i), {rulo, ruhi}, {elo, ehi});
      chk($sformatf("vec%0d_u_cc", i), {60'b0, rucc}, {60'b0, ecc});
    end

    run(2'b01, 32'hffff_fffd, 32'd5, lat, rlo, rhi, rulo, ruhi, rcc, rucc);
    chk("unsigned_muls_lo", {32'b0, rulo}, 64'hffff_fff1);
    chk("unsigned_muls_hi", {32'b0, ruhi}, 64'h4);

    plo = lo; phi = hi; pcc = cc;
    op = 2'b00; a = 32'd12345; b = 32'd6789; start = 1'b1;
    tick();
    start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("abort_busy_before", {63'b0, busy}, 64'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    if (done) seen = 1'b1;
    chk("abort_ready", {63'b0, ready}, 64'd1);
    chk("abort_no_done", {63'b0, seen}, 64'd0);
    chk("abort_results_kept", {lo, hi}, {plo, phi});
    chk("abort_cc_kept", {60'b0, cc}, {60'b0, pcc});

    op = 2'b10; a = 32'd1000; b = 32'd7; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    op = 2'b00; a = 32'd5; b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      tick();
      lat++;
    end
    chk("busy_start_lo", {32'b0, lo}, 64'd142);
    chk("busy_start_hi", {32'b0, hi}, 64'd6);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("busy_start_dropped", {63'b0, seen}, 64'd0);

    for (int i = 0; i < 150; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = '0;
        1: rb = 32'($urandom_range(1, 16));
        2: ra = 32'($urandom_range(0, 300));
        3: begin ra = 32'h8000_0000; rb = 32'hffff_ffff; end
        default: ;
      endcase
      run(rop, ra, rb, lat, rlo, rhi, rulo, ruhi, rcc, rucc);
      chk($sformatf("rnd%0d_lat", i), 64'(lat),
          64'((rop[1] && rb == 0) ? 1 : 33));
      model(rop, ra, rb, 1'b1, elo, ehi, ecc);
      chk($sformatf("rnd%0d_s op%0d %h %h", i, rop, ra, rb),
          {rlo, rhi}, {elo, ehi});
      chk($sformatf("rnd%0d_s_cc", i), {60'b0, rcc}, {60'b0, ecc});
      model(rop, ra, rb, 1'b0, elo, ehi, ecc);
      chk($sformatf("rnd%0d_u op%0d %h %h", i, rop, ra, rb),
          {rulo, ruhi}, {elo, ehi});
      chk($sformatf("rnd%0d_u_cc", i), {60'b0, rucc}, {60'b0, ecc});
    end

    op = 2'b01; a = 32'hffff_fff0; b = 32'd77; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_f = 1'b1;
    tick();
    chk("midrst_ready", {62'b0, ready, ready_u}, 64'd0);
    chk("midrst_done", {62'b0, done, done_u}, 64'd0);
    chk("midrst_results", {lo, hi}, 64'd0);
    chk("midrst_cc", {56'b0, cc, cc_u}, 64'd0);
    rst_f = 1'b0;
    tick();
    chk("midrst_ready_after", {63'b0, ready}, 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    chk("midrst_no_done", {63'b0, seen}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
